// File: rtl/laggy_prefix_offset.sv
// Multi-cycle prefix popcount: offset of a queued bit position within the compressed bitmask_a array.
// Optional macro LAGGY_PREFIX_FIFO_BYPASS_EN loads a match straight into CALC when idle and the FIFO is empty.
module laggy_prefix_offset #(
  parameter int BITMASK_WIDTH = 16,
  parameter int NUM_ADDERS    = 16,
  parameter int WEIGHT_WIDTH  = 8,
  parameter int FIFO_DEPTH    = 8,
  localparam int PW           = $clog2(BITMASK_WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [BITMASK_WIDTH-1:0] and_result,
  input  logic [BITMASK_WIDTH-1:0] bitmask_a,
  input  logic [PW-1:0]            matched_position,
  input  logic [WEIGHT_WIDTH-1:0]  matched_weight,
  input  logic                     valid_match,
  output logic [PW-1:0]            slow_offset,
  output logic                     slow_valid,
  output logic                     ready_for_new_calc,
  output logic                     fifo_empty,
  output logic                     fifo_full
);

  localparam int NCHUNK = BITMASK_WIDTH / NUM_ADDERS;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam logic [KW-1:0] K_LAST   = KW'(NCHUNK - 1);
  localparam logic [KW-1:0] K_ONE    = KW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [0:0] {IDLE, CALC} state_t;

  state_t                   state;
  logic [KW-1:0]            k;
  logic [PW:0]              acc;
  logic [PW:0]              acc_next;
  logic [PW-1:0]            current_position;
  logic [WEIGHT_WIDTH-1:0]  current_weight;
  logic [BITMASK_WIDTH-1:0] mask_q;
  logic [BITMASK_WIDTH-1:0] below_mask;
  logic [NUM_ADDERS-1:0]    chunk_bits;

  logic [PW-1:0]            pos_mem [FIFO_DEPTH];
  logic [WEIGHT_WIDTH-1:0]  wt_mem  [FIFO_DEPTH];
  logic [AW-1:0]            wr_ptr;
  logic [AW-1:0]            rd_ptr;
  logic [AW:0]              count;
  logic [PW-1:0]            fifo_mp_out;
  logic [WEIGHT_WIDTH-1:0]  fifo_wt_out;
  logic                     fifo_read_en;
  logic                     fifo_write_en;
  logic                     bypass_take;
  logic                     unused_sink;

  function automatic logic [PW:0] popcount(input logic [NUM_ADDERS-1:0] v);
    logic [PW:0] cnt;
    cnt = '0;
    for (int j = 0; j < NUM_ADDERS; j++) cnt = cnt + {{PW{1'b0}}, v[j]};
    return cnt;
  endfunction

  assign fifo_empty         = (count == '0);
  assign fifo_full          = (count == CNT_FULL);
  assign ready_for_new_calc = (state == IDLE);
  assign fifo_mp_out        = pos_mem[rd_ptr];
  assign fifo_wt_out        = wt_mem[rd_ptr];
  assign fifo_read_en       = (state == IDLE) && !fifo_empty;

`ifdef LAGGY_PREFIX_FIFO_BYPASS_EN
  assign bypass_take = (state == IDLE) && fifo_empty && valid_match;
`else
  assign bypass_take = 1'b0;
`endif

  // A write while full is dropped even if the head pops on the same edge.
  assign fifo_write_en = valid_match && !fifo_full && !bypass_take;

  // Weight travels with the position but is not consumed by this stage.
  assign unused_sink = ^{and_result, current_weight};

  always_comb begin
    below_mask = '0;
    for (int i = 0; i < BITMASK_WIDTH; i++) below_mask[i] = (i < int'(current_position));
  end

  always_comb begin
    chunk_bits = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      if (k == KW'(c)) chunk_bits = mask_q[c*NUM_ADDERS +: NUM_ADDERS] & below_mask[c*NUM_ADDERS +: NUM_ADDERS];
    end
  end

  assign acc_next = acc + popcount(chunk_bits);

  always_ff @(posedge clk) begin
    if (fifo_write_en) begin
      pos_mem[wr_ptr] <= matched_position;
      wt_mem[wr_ptr]  <= matched_weight;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (fifo_write_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (fifo_read_en)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({fifo_write_en, fifo_read_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      k           <= '0;
      slow_valid  <= 1'b0;
      slow_offset <= '0;
    end else begin
      slow_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (fifo_read_en || bypass_take) begin
            state <= CALC;
            k     <= '0;
          end
        end
        CALC: begin
          if (k == K_LAST) begin
            state       <= IDLE;
            slow_offset <= acc_next[PW-1:0];
            slow_valid  <= 1'b1;
          end else begin
            k <= k + K_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand capture at dequeue, then one chunk accumulated per CALC cycle.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (bypass_take) begin
        current_position <= matched_position;
        current_weight   <= matched_weight;
      end else if (fifo_read_en) begin
        current_position <= fifo_mp_out;
        current_weight   <= fifo_wt_out;
      end
      mask_q <= bitmask_a;
      acc    <= '0;
    end else begin
      acc <= acc_next;
    end
  end

endmodule

// File: tb/tb_laggy_prefix_offset.sv
// Bench for laggy_prefix_offset: three instances (NCHUNK 1, 4 and 16) against a queue-based reference model.
module tb_laggy_prefix_offset;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] mask_tb = '0;
  logic [5:0]  pos_tb = '0;
  logic [7:0]  wt_tb = '0;
  logic        vm = 1'b0;

  always #5 clk = ~clk;

  wire       sv [3];
  wire       rd [3];
  wire       fe [3];
  wire       ff [3];
  wire [3:0] so0;
  wire [3:0] so1;
  wire [5:0] so2;
  wire [5:0] so_all [3];
  assign so_all[0] = {2'b00, so0};
  assign so_all[1] = {2'b00, so1};
  assign so_all[2] = so2;

  laggy_prefix_offset #(.BITMASK_WIDTH(16), .NUM_ADDERS(16), .WEIGHT_WIDTH(8), .FIFO_DEPTH(8)) dut0 (
    .clk(clk), .rst(rst), .and_result(mask_tb[15:0]), .bitmask_a(mask_tb[15:0]),
    .matched_position(pos_tb[3:0]), .matched_weight(wt_tb), .valid_match(vm),
    .slow_offset(so0), .slow_valid(sv[0]), .ready_for_new_calc(rd[0]),
    .fifo_empty(fe[0]), .fifo_full(ff[0]));

  laggy_prefix_offset #(.BITMASK_WIDTH(16), .NUM_ADDERS(4), .WEIGHT_WIDTH(8), .FIFO_DEPTH(8)) dut4 (
    .clk(clk), .rst(rst), .and_result(mask_tb[15:0]), .bitmask_a(mask_tb[15:0]),
    .matched_position(pos_tb[3:0]), .matched_weight(wt_tb), .valid_match(vm),
    .slow_offset(so1), .slow_valid(sv[1]), .ready_for_new_calc(rd[1]),
    .fifo_empty(fe[1]), .fifo_full(ff[1]));

  laggy_prefix_offset #(.BITMASK_WIDTH(64), .NUM_ADDERS(4), .WEIGHT_WIDTH(8), .FIFO_DEPTH(8)) dut64 (
    .clk(clk), .rst(rst), .and_result(mask_tb), .bitmask_a(mask_tb),
    .matched_position(pos_tb), .matched_weight(wt_tb), .valid_match(vm),
    .slow_offset(so2), .slow_valid(sv[2]), .ready_for_new_calc(rd[2]),
    .fifo_empty(fe[2]), .fifo_full(ff[2]));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: per instance a list of pending positions and a countdown for the busy unit.
  function automatic int nch(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 4 : 16);
  endfunction

  function automatic int exp_offset(input int k, input int p);
    logic [63:0] m;
    m = (k == 2) ? mask_tb : {48'd0, mask_tb[15:0]};
    return $countones(m & ((64'd1 << p) - 64'd1));
  endfunction

  bit model_on = 1'b0;
  int mq [3][16];
  int mn [3];
  bit mbusy [3];
  int mtim [3];
  int mcur [3];
  bit ev [3];
  int eo [3];

  always @(posedge clk) begin
    bit was_full, was_empty;
    if (!rst) begin
      model_on = 1'b1;
      for (int k = 0; k < 3; k++) begin
        mn[k] = 0; mbusy[k] = 1'b0; ev[k] = 1'b0; eo[k] = 0; mtim[k] = 0;
      end
    end else if (model_on) begin
      for (int k = 0; k < 3; k++) begin
        was_full  = (mn[k] == 8);
        was_empty = (mn[k] == 0);
        ev[k] = 1'b0;
        if (mbusy[k]) begin
          mtim[k]--;
          if (mtim[k] == 0) begin
            ev[k] = 1'b1; eo[k] = mcur[k]; mbusy[k] = 1'b0;
          end
        end else if (!was_empty) begin
          mcur[k] = exp_offset(k, mq[k][0]);
          for (int i = 0; i < 15; i++) mq[k][i] = mq[k][i+1];
          mn[k]--;
          mbusy[k] = 1'b1;
          mtim[k] = nch(k);
        end
        if (vm && !was_full) begin
          mq[k][mn[k]] = (k == 2) ? int'(pos_tb) : int'(pos_tb[3:0]);
          mn[k]++;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (model_on) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("slow_valid[%0d]", k), sv[k], ev[k]);
        chk($sformatf("slow_offset[%0d]", k), so_all[k], eo[k]);
        chk($sformatf("ready[%0d]", k), rd[k], !mbusy[k]);
        chk($sformatf("fifo_empty[%0d]", k), fe[k], mn[k] == 0);
        chk($sformatf("fifo_full[%0d]", k), ff[k], mn[k] == 8);
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int p0o[$], p0c[$], p1o[$], p1c[$], p2o[$], p2c[$];
  always @(posedge clk) begin
    #1;
    if (sv[0] === 1'b1) begin p0o.push_back(int'(so0)); p0c.push_back(cyc); end
    if (sv[1] === 1'b1) begin p1o.push_back(int'(so1)); p1c.push_back(cyc); end
    if (sv[2] === 1'b1) begin p2o.push_back(int'(so2)); p2c.push_back(cyc); end
  end

  task automatic clear_rec();
    p0o.delete(); p0c.delete(); p1o.delete(); p1c.delete(); p2o.delete(); p2c.delete();
  endtask

  task automatic push(input int p, input int w, output int wc);
    @(negedge clk);
    pos_tb = 6'(p); wt_tb = 8'(w); vm = 1'b1;
    @(posedge clk);
    #1 wc = cyc;
    @(negedge clk);
    vm = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    int seq [3] = '{5, 3, 2};
    int exp_seq [3] = '{2, 1, 0};

    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset slow_valid", sv[0], 1'b0);
    chk("reset slow_offset", so0, 0);
    chk("reset fifo_empty", fe[0], 1'b1);
    chk("reset fifo_full", ff[0], 1'b0);
    chk("reset ready", rd[0], 1'b1);
    chk("reset ready nchunk4", rd[1], 1'b1);
    rst = 1'b1;

    mask_tb = 64'h002C;
    clear_rec();
    push(5, 8'h5A, wc);
    repeat (24) @(negedge clk);
    chk("pos5 pulses", p0o.size(), 1);
    if (p0o.size() >= 1) begin
      chk("pos5 offset", p0o[0], 2);
      chk("pos5 latency", p0c[0] - wc, 2);
    end
    chk("pos5 fifo_empty after", fe[0], 1'b1);

    clear_rec();
    push(3, 8'h11, wc);
    repeat (24) @(negedge clk);
    chk("pos3 pulses", p0o.size(), 1);
    if (p0o.size() >= 1) chk("pos3 offset", p0o[0], 1);

    clear_rec();
    push(2, 8'h22, wc);
    repeat (24) @(negedge clk);
    chk("pos2 pulses", p0o.size(), 1);
    if (p0o.size() >= 1) chk("pos2 offset", p0o[0], 0);

    clear_rec();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      pos_tb = 6'(seq[i]); wt_tb = 8'(i); vm = 1'b1;
    end
    @(negedge clk);
    vm = 1'b0;
    repeat (60) @(negedge clk);
    chk("burst pulses", p0o.size(), 3);
    if (p0o.size() == 3) begin
      for (int i = 0; i < 3; i++) chk($sformatf("burst offset %0d", i), p0o[i], exp_seq[i]);
      chk("burst spacing 0-1", p0c[1] - p0c[0], 2);
      chk("burst spacing 1-2", p0c[2] - p0c[1], 2);
    end
    chk("burst pulses nchunk4", p1o.size(), 3);
    if (p1o.size() == 3) chk("burst spacing nchunk4", p1c[1] - p1c[0], 5);

    mask_tb = 64'hFFFF;
    clear_rec();
    push(15, 8'h33, wc);
    repeat (24) @(negedge clk);
    chk("nchunk4 pulses", p1o.size(), 1);
    if (p1o.size() >= 1) begin
      chk("nchunk4 offset", p1o[0], 15);
      chk("nchunk4 latency", p1c[0] - wc, 5);
    end

    mask_tb = 64'hFFFF_FFFF_FFFF_FFFF;
    clear_rec();
    push(40, 8'h44, wc);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      pos_tb = 6'(i + 1); wt_tb = 8'(i); vm = 1'b1;
      @(posedge clk);
      #1;
      if (i == 7) chk("full after 8th write", ff[2], 1'b1);
      if (i == 8) chk("full after dropped 9th", ff[2], 1'b1);
    end
    @(negedge clk);
    vm = 1'b0;
    chk("busy before abort", rd[2], 1'b0);
    @(negedge clk);
    rst = 1'b0;
    clear_rec();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort no pulse", p2o.size(), 0);
    chk("abort fifo_empty", fe[2], 1'b1);
    chk("abort fifo_full", ff[2], 1'b0);
    chk("abort ready", rd[2], 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
